// File: rtl/sam_mc6883.sv
// sam_mc6883: MC6883 SAM model.
// Generates the 6809E E/Q quadrature clocks and decodes CPU addresses into a 74138 select
// code plus a latched memory address. It owns the 16-bit SAM control register, selects
// the bus rate, and runs the VDG video address counter with row repeat.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   cpu_addr     6809E address bus
//   cpu_rw       1 = read, 0 = write
//   e, q         6809E E and Q clocks (registered)
//   s            74138 select code (0 RAM .. 7 none), latched at Q rise
//   ram_addr     mapped memory address, latched at Q rise
//   vdg_da0_en   one-clk strobe per VDG byte fetch
//   vdg_hs_n     VDG horizontal sync, active low
//   vdg_fs_n     VDG field sync, active low
//   vid_addr     video fetch address
//   sam_reg      control register readback
module sam_mc6883 #(
    parameter int unsigned PHASE_LEN = 14,
    parameter int unsigned RAM_AW    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw,
    output logic              e,
    output logic              q,
    output logic [2:0]        s,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic              vdg_da0_en,
    input  logic              vdg_hs_n,
    input  logic              vdg_fs_n,
    output logic [RAM_AW-1:0] vid_addr,
    output logic [15:0]       sam_reg
);

    localparam int unsigned PhW = (PHASE_LEN > 2) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PhW-1:0] SlowLast = PhW'(PHASE_LEN - 1);
    localparam logic [PhW-1:0] FastLast = PhW'(PHASE_LEN / 2 - 1);

    typedef enum logic [1:0] {StQ0, StQ1, StQ2, StQ3} quarter_e;

    // ------------------------------------------------------------------
    // Clock sequencer
    // ------------------------------------------------------------------
    quarter_e       quarter_q, quarter_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic           e_q, e_d;
    logic           q_q, q_d;
    logic           fast_q, fast_d;
    logic           phase_last;
    logic           q_rise;
    logic           e_fall;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            quarter_q <= StQ0;
            phase_q   <= '0;
            e_q       <= 1'b0;
            q_q       <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            quarter_q <= quarter_d;
            phase_q   <= phase_d;
            e_q       <= e_d;
            q_q       <= q_d;
            fast_q    <= fast_d;
        end
    end

    // Next-state
    always_comb begin
        phase_last = (phase_q == (fast_q ? FastLast : SlowLast));
        quarter_d  = quarter_q;
        phase_d    = phase_q + PhW'(1);
        if (phase_last) begin
            phase_d = '0;
            unique case (quarter_q)
                StQ0:    quarter_d = StQ1;
                StQ1:    quarter_d = StQ2;
                StQ2:    quarter_d = StQ3;
                default: quarter_d = StQ0;
            endcase
        end
    end

    // Outputs are computed from the next quarter so E/Q come straight from flops
    always_comb begin
        e_d    = (quarter_d == StQ2) || (quarter_d == StQ3);
        q_d    = (quarter_d == StQ1) || (quarter_d == StQ2);
        q_rise = phase_last && (quarter_q == StQ0);
        e_fall = phase_last && (quarter_q == StQ3);
    end

    // ------------------------------------------------------------------
    // Control register and rate selection
    // ------------------------------------------------------------------
    logic [15:0] sam_reg_q, sam_reg_d;
    logic        reg_wr;
    logic        in_rom_space;

    always_comb begin
        sam_reg_d = sam_reg_q;
        reg_wr    = e_fall && !cpu_rw && (cpu_addr[15:5] == 11'h7FE);
        if (reg_wr) begin
            sam_reg_d[cpu_addr[4:1]] = cpu_addr[0];
        end

        // The rate decision uses the register value including a write committing on
        // this same edge, so the cycle right after a rate write already runs at the new rate.
        in_rom_space = cpu_addr[15] && (cpu_addr[15:8] != 8'hFF);
        fast_d       = fast_q;
        if (e_fall) begin
            unique case (sam_reg_d[12:11])
                2'b00:   fast_d = 1'b0;
                2'b01:   fast_d = in_rom_space && !sam_reg_d[15];
                default: fast_d = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address decode and latch
    // ------------------------------------------------------------------
    logic [2:0]        s_q, s_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [2:0]        dec_s;
    logic [15:0]       dec_addr;
    logic              ty;
    logic [1:0]        mm;
    logic              p1;

    always_comb begin
        ty       = sam_reg_q[15];
        mm       = sam_reg_q[14:13];
        p1       = sam_reg_q[10];
        dec_s    = 3'd7;
        dec_addr = cpu_addr;
        if (!cpu_addr[15]) begin
            dec_s = 3'd0;
            // Map type 0, 64K mode with page 1 selected: lower 32K shows the upper bank
            if (!ty && (mm == 2'b10) && p1) begin
                dec_addr = cpu_addr | 16'h8000;
            end
        end else if (cpu_addr[15:8] != 8'hFF) begin
            if (ty) begin
                dec_s = 3'd0;
            end else begin
                unique case (cpu_addr[14:13])
                    2'b00:   dec_s = 3'd1;
                    2'b01:   dec_s = 3'd2;
                    default: dec_s = 3'd3;
                endcase
            end
        end else begin
            unique case (cpu_addr[7:5])
                3'd0:    dec_s = 3'd4;
                3'd1:    dec_s = 3'd5;
                3'd2:    dec_s = 3'd6;
                3'd7: begin
                    // Vectors are fetched from the top of the $A000 ROM
                    dec_s    = 3'd2;
                    dec_addr = cpu_addr & ~16'h4000;
                end
                default: dec_s = 3'd7;
            endcase
        end

        s_d        = s_q;
        ram_addr_d = ram_addr_q;
        if (q_rise) begin
            s_d        = dec_s;
            ram_addr_d = RAM_AW'(dec_addr);
        end
    end

    // ------------------------------------------------------------------
    // Video address counter
    // ------------------------------------------------------------------
    logic [RAM_AW-1:0] vid_addr_q, vid_addr_d;
    logic [RAM_AW-1:0] row_start_q, row_start_d;
    logic [3:0]        row_cnt_q, row_cnt_d;
    logic              fs_q, fs_prev_q;
    logic              hs_q, hs_prev_q;
    logic              fs_fall, hs_fall;
    logic [3:0]        rep_m1;
    logic [15:0]       field_base;

    always_comb begin
        unique case (sam_reg_q[2:0])
            3'd0:    rep_m1 = 4'd11;
            3'd1:    rep_m1 = 4'd2;
            3'd2:    rep_m1 = 4'd2;
            3'd3:    rep_m1 = 4'd1;
            3'd4:    rep_m1 = 4'd1;
            default: rep_m1 = 4'd0;
        endcase

        fs_fall    = fs_prev_q && !fs_q;
        hs_fall    = hs_prev_q && !hs_q;
        field_base = {sam_reg_q[9:3], 9'b0};

        vid_addr_d  = vid_addr_q;
        row_start_d = row_start_q;
        row_cnt_d   = row_cnt_q;
        // Priority fs > hs > da0; a lower event in the same clk is lost
        if (fs_fall) begin
            vid_addr_d  = RAM_AW'(field_base);
            row_start_d = RAM_AW'(field_base);
            row_cnt_d   = 4'd0;
        end else if (hs_fall) begin
            if (row_cnt_q < rep_m1) begin
                vid_addr_d = row_start_q;
                row_cnt_d  = row_cnt_q + 4'd1;
            end else begin
                row_start_d = vid_addr_q;
                row_cnt_d   = 4'd0;
            end
        end else if (vdg_da0_en) begin
            vid_addr_d = vid_addr_q + RAM_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sam_reg_q   <= 16'h0000;
            s_q         <= 3'd7;
            ram_addr_q  <= '0;
            vid_addr_q  <= '0;
            row_start_q <= '0;
            row_cnt_q   <= 4'd0;
            fs_q        <= 1'b1;
            fs_prev_q   <= 1'b1;
            hs_q        <= 1'b1;
            hs_prev_q   <= 1'b1;
        end else begin
            sam_reg_q   <= sam_reg_d;
            s_q         <= s_d;
            ram_addr_q  <= ram_addr_d;
            vid_addr_q  <= vid_addr_d;
            row_start_q <= row_start_d;
            row_cnt_q   <= row_cnt_d;
            fs_q        <= vdg_fs_n;
            fs_prev_q   <= fs_q;
            hs_q        <= vdg_hs_n;
            hs_prev_q   <= hs_q;
        end
    end

    assign e        = e_q;
    assign q        = q_q;
    assign s        = s_q;
    assign ram_addr = ram_addr_q;
    assign vid_addr = vid_addr_q;
    assign sam_reg  = sam_reg_q;

endmodule

// File: tb/tb_sam_mc6883.sv
// Self-checking bench for sam_mc6883 (default parameters: PHASE_LEN=14, RAM_AW=16).
module tb_sam_mc6883;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'hFF60;
    logic        cpu_rw = 1'b1;
    logic        e, q;
    logic [2:0]  s;
    logic [15:0] ram_addr;
    logic        vdg_da0_en = 1'b0;
    logic        vdg_hs_n = 1'b1;
    logic        vdg_fs_n = 1'b1;
    logic [15:0] vid_addr;
    logic [15:0] sam_reg;

    sam_mc6883 dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .e          (e),
        .q          (q),
        .s          (s),
        .ram_addr   (ram_addr),
        .vdg_da0_en (vdg_da0_en),
        .vdg_hs_n   (vdg_hs_n),
        .vdg_fs_n   (vdg_fs_n),
        .vid_addr   (vid_addr),
        .sam_reg    (sam_reg)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;
    int clk_cnt   = 0;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model of the control register, updated as writes are issued
    logic [15:0] model_reg = 16'h0000;

    function automatic logic [18:0] exp_decode(input logic [15:0] a, input logic [15:0] r);
        logic [2:0]  es;
        logic [15:0] ea;
        es = 3'd7;
        ea = a;
        if (a < 16'h8000) begin
            es = 3'd0;
            if (!r[15] && r[14:13] == 2'b10 && r[10]) ea = a | 16'h8000;
        end else if (a <= 16'hFEFF) begin
            if (r[15])              es = 3'd0;
            else if (a < 16'hA000)  es = 3'd1;
            else if (a < 16'hC000)  es = 3'd2;
            else                    es = 3'd3;
        end else if (a < 16'hFF20) es = 3'd4;
        else if (a < 16'hFF40)     es = 3'd5;
        else if (a < 16'hFF60)     es = 3'd6;
        else if (a < 16'hFFE0)     es = 3'd7;
        else begin
            es = 3'd2;
            ea = a & 16'hBFFF;
        end
        return {es, ea};
    endfunction

    // Scoreboard: expected decode pushed when an address is driven, popped at Q rise
    logic [18:0] exp_q[$];
    logic [18:0] exp_hold = {3'd7, 16'hFF60};
    logic        q_prev;
    logic        mon_en = 1'b1;

    always @(negedge clk) begin
        logic [18:0] cur;
        if (mon_en && q === 1'b1 && q_prev === 1'b0) begin
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : exp_hold;
            chk("decode_s", {29'd0, s}, {29'd0, cur[18:16]});
            chk("decode_ram_addr", {16'd0, ram_addr}, {16'd0, cur[15:0]});
            exp_hold <= cur;
        end
        q_prev <= q;
    end

    // Drive an address during quarter 3 (E high, Q low) of the next bus cycle: it is
    // written on this cycle's E fall and decoded at the following Q rise.
    task automatic bus_cycle(input logic [15:0] a, input logic rw);
        int guard = 0;
        while (e !== 1'b0 && guard < 400) begin @(negedge clk); guard++; end
        while (!(e === 1'b1 && q === 1'b0) && guard < 400) begin @(negedge clk); guard++; end
        chk("bus_cycle_timeout", {31'd0, guard < 400}, 32'd1);
        if (!rw && a >= 16'hFFC0 && a <= 16'hFFDF) model_reg[a[4:1]] = a[0];
        cpu_addr = a;
        cpu_rw   = rw;
        exp_q.push_back(exp_decode(a, model_reg));
    endtask

    task automatic wait_efall(output int t);
        logic pe;
        int   i;
        pe = e;
        t  = -1;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pe === 1'b1 && e === 1'b0) begin
                t = clk_cnt;
                break;
            end
            pe = e;
        end
        chk("efall_timeout", {31'd0, t >= 0}, 32'd1);
    endtask

    task automatic da0_strobe();
        @(negedge clk) vdg_da0_en = 1'b1;
        @(negedge clk) vdg_da0_en = 1'b0;
    endtask

    task automatic sync_pulse(input logic fs, input logic hs);
        @(negedge clk);
        if (fs) vdg_fs_n = 1'b0;
        if (hs) vdg_hs_n = 1'b0;
        repeat (3) @(negedge clk);
        vdg_fs_n = 1'b1;
        vdg_hs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0, t1, ta, tb, tc;
        int q_rise_k, e_rise_k, e_fall_k;

        // ---------------- reset state and clock shape ----------------
        exp_q.push_back({3'd7, 16'hFF60});
        repeat (3) @(posedge clk);
        #1;
        chk("rst_e", {31'd0, e}, 32'd0);
        chk("rst_q", {31'd0, q}, 32'd0);
        chk("rst_s", {29'd0, s}, 32'd7);
        chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        chk("rst_vid_addr", {16'd0, vid_addr}, 32'd0);
        chk("rst_sam_reg", {16'd0, sam_reg}, 32'd0);
        @(negedge clk) reset = 1'b0;
        q_rise_k = 0;
        e_rise_k = 0;
        e_fall_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (q === 1'b1 && q_rise_k == 0) q_rise_k = k;
            if (e === 1'b1 && e_rise_k == 0) e_rise_k = k;
            if (e === 1'b0 && e_rise_k != 0 && e_fall_k == 0) e_fall_k = k;
        end
        chk("q_rise_clk", q_rise_k, 32'd14);
        chk("e_rise_clk", e_rise_k, 32'd28);
        chk("e_fall_clk", e_fall_k, 32'd56);
        wait_efall(t0);
        wait_efall(t1);
        chk("slow_period", t1 - t0, 32'd56);

        // ---------------- register writes ----------------
        bus_cycle(16'hFFC7, 1'b0);
        bus_cycle(16'hFFC9, 1'b0);
        bus_cycle(16'hFFDF, 1'b0);
        wait_efall(t0);
        chk("reg_after_3_writes", {16'd0, sam_reg}, 32'h8018);
        chk("reg_vs_model_a", {16'd0, sam_reg}, {16'd0, model_reg});
        bus_cycle(16'hFFDE, 1'b0);
        wait_efall(t0);
        chk("reg_ty_cleared", {16'd0, sam_reg}, 32'h0018);

        // ---------------- decode and map ----------------
        bus_cycle(16'h1234, 1'b1);
        bus_cycle(16'hA000, 1'b1);
        bus_cycle(16'hFF22, 1'b1);
        bus_cycle(16'hFFFE, 1'b1);
        bus_cycle(16'hFF02, 1'b1);
        bus_cycle(16'hC100, 1'b1);
        bus_cycle(16'h8800, 1'b1);
        bus_cycle(16'hFF45, 1'b1);
        bus_cycle(16'hFFDF, 1'b0);
        bus_cycle(16'h9000, 1'b1);
        bus_cycle(16'hFFDE, 1'b0);
        bus_cycle(16'hFFDD, 1'b0);
        bus_cycle(16'hFFD5, 1'b0);
        bus_cycle(16'h0100, 1'b1);
        bus_cycle(16'hFF60, 1'b1);
        wait_efall(t0);
        chk("reg_vs_model_b", {16'd0, sam_reg}, {16'd0, model_reg});

        // ---------------- rate ----------------
        bus_cycle(16'hFFD9, 1'b0);
        wait_efall(t0);
        bus_cycle(16'hFF60, 1'b1);
        wait_efall(t1);
        chk("fast_r2_len", t1 - t0, 32'd28);
        bus_cycle(16'hFFD8, 1'b0);
        bus_cycle(16'hFFD7, 1'b0);
        bus_cycle(16'hA000, 1'b1);
        wait_efall(ta);
        bus_cycle(16'h0400, 1'b1);
        wait_efall(tb);
        bus_cycle(16'hFF60, 1'b1);
        wait_efall(tc);
        chk("r1_rom_len", tb - ta, 32'd28);
        chk("r1_ram_len", tc - tb, 32'd56);
        bus_cycle(16'hFFD6, 1'b0);
        bus_cycle(16'hFFC6, 1'b0);
        bus_cycle(16'hFF60, 1'b1);
        wait_efall(t0);
        chk("reg_before_video", {16'd0, sam_reg}, 32'h4410);

        // ---------------- video rows, V=0 F=2 ----------------
        sync_pulse(1'b1, 1'b0);
        chk("vid_after_fs", {16'd0, vid_addr}, 32'h0400);
        for (int line = 1; line <= 12; line++) begin
            for (int b = 0; b < 32; b++) da0_strobe();
            if (line == 1) chk("vid_line_end", {16'd0, vid_addr}, 32'h0420);
            sync_pulse(1'b0, 1'b1);
            chk($sformatf("vid_after_hs_line%0d", line), {16'd0, vid_addr},
                (line < 12) ? 32'h0400 : 32'h0420);
        end

        // V=6: every hs advances the row start
        bus_cycle(16'hFFC3, 1'b0);
        bus_cycle(16'hFFC5, 1'b0);
        bus_cycle(16'hFF60, 1'b1);
        wait_efall(t0);
        for (int line = 0; line < 2; line++) begin
            for (int b = 0; b < 32; b++) da0_strobe();
            sync_pulse(1'b0, 1'b1);
            chk($sformatf("vid_v6_line%0d", line), {16'd0, vid_addr},
                32'h0440 + 32'(line) * 32'h20);
        end

        // ---------------- priority: fs+hs together, da0 in the fs clk ----------------
        for (int b = 0; b < 4; b++) da0_strobe();
        chk("vid_pre_prio", {16'd0, vid_addr}, 32'h0464);
        @(negedge clk);
        vdg_fs_n = 1'b0;
        vdg_hs_n = 1'b0;
        @(negedge clk) vdg_da0_en = 1'b1;
        @(negedge clk) vdg_da0_en = 1'b0;
        repeat (3) @(negedge clk);
        vdg_fs_n = 1'b1;
        vdg_hs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("vid_prio_fs", {16'd0, vid_addr}, 32'h0400);

        // ---------------- reset mid-cycle during quarter 2 ----------------
        mon_en = 1'b0;
        begin
            int guard = 0;
            while (!(e === 1'b1 && q === 1'b1) && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            chk("q2_timeout", {31'd0, guard < 400}, 32'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_e", {31'd0, e}, 32'd0);
        chk("mid_rst_q", {31'd0, q}, 32'd0);
        chk("mid_rst_vid", {16'd0, vid_addr}, 32'd0);
        chk("mid_rst_sam_reg", {16'd0, sam_reg}, 32'd0);
        chk("mid_rst_s", {29'd0, s}, 32'd7);
        chk("mid_rst_ram_addr", {16'd0, ram_addr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
